alu_pipe_nbits: RTL
===================

// Module: alu_pipe_nbits
// PURPOSE
//  Parametrised, 2-stage pipelined successor of the 8-bit combinational ALU: same 3-bit opcode set,
//  WIDTH-bit operands, valid/ready flow control on both sides, carry + signed-overflow flags and a
//  sticky overflow status. Sits between the sequencing FSM and the register file / result bus.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=2)
//  STICKY  1  1: ovf_sticky accumulates; 0: ovf_sticky held at 0
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  reset       in   1      synchronous, active-high
//  in_valid    in   1      operation offered
//  in_ready    out  1      stage 1 can accept
//  op          in   3      000 NOP,001 ADD,010 SUB,011 INC,100 DEC,101 AND,110 XOR,111 NOT
//  a, b        in   WIDTH  operands (b ignored for INC/DEC/NOT/NOP)
//  acc_sel     in   1      ALU_ACC_EN only: use last result as operand a
//  out_valid   out  1      result available
//  out_ready   in   1      consumer accepts result
//  r           out  WIDTH  result
//  carry       out  1      carry-out (ADD/INC) / borrow (SUB/DEC); 0 for logic ops and NOP
//  ovf         out  1      signed two's-complement overflow of this result; 0 for logic ops and NOP
//  ovf_sticky  out  1      OR of every delivered ovf since reset or clr_sticky
//  clr_sticky  in   1      clears ovf_sticky (wins over a same-cycle set)
// BEHAVIOUR
//  - Reset (sync, active-high, any cycle incl. mid-operation): both stages emptied, in-flight ops
//    dropped; out_valid=0, r=0, carry=0, ovf=0, ovf_sticky=0, acc=0; in_ready=1 from next cycle.
//  - Stage 1 registers {op,a,b,acc_sel}; stage 2 registers {r,carry,ovf}. Latency 2 cycles from
//    accepted in_valid&&in_ready to out_valid, with no backpressure. Throughput 1 op/cycle.
//  - Handshake: transfer when valid&&ready. adv2 = !out_valid || out_ready; stage 1 moves to stage 2
//    when s1_valid&&adv2; in_ready = !s1_valid || adv2 (combinational, no path from in_valid).
//    Outputs and r/carry/ovf stay stable while out_valid&&!out_ready.
//  - Arithmetic modulo 2^WIDTH. ADD a+b; SUB a-b; INC a+1; DEC a-1; AND a&b; XOR a^b; NOT ~a.
//    ovf (ADD/INC): operands same sign, result sign differs; (SUB/DEC): signs differ, result sign != a.
//    carry = bit WIDTH of the (WIDTH+1)-bit sum; for SUB/DEC carry=1 means borrow (a<b unsigned).
//  - NOP is a real transaction: r=0, carry=0, ovf=0, out_valid asserted as for any op.
//  - ovf_sticky sets on out_valid&&out_ready&&ovf (delivery, not compute). clr_sticky has priority.
//  - Boundaries: 7F+01 -> 80 ovf=1 carry=0; FF+01 -> 00 carry=1 ovf=0; 00-01 -> FF borrow=1 ovf=0;
//    80-01 -> 7F ovf=1; simultaneous accept and deliver in one cycle is legal (full pipe, no bubble).
// CONFIGURATION
//  ALU_ACC_EN defined: accumulator register acc updates with r on every delivered result; stage 1
//    substitutes acc for a when acc_sel=1. Chained op accepted while its predecessor is still in
//    stage 2 uses acc as of the cycle of execution (forwarded from stage-2 r), i.e. always the
//    previous delivered-or-pending result in program order.
//  ALU_ACC_EN undefined: no acc register; acc_sel ignored; a always used.
// STRUCTURE
//  - Package alu_pkg: op-code localparams (OP_NOP..OP_NOT), 3-bit op typedef, shared with the
//    sequencer FSM and testbench.
//  - One sub-module alu_core_nbits: purely combinational WIDTH-parametrised op/flag evaluation;
//    top holds pipeline registers, handshake, sticky flag and optional accumulator.
// TESTING (WIDTH=8 unless noted)
//  1 reset, then ADD 7F,01 with out_ready=1 -> after 2 cycles r=80 ovf=1 carry=0, ovf_sticky=1.
//  2 back-to-back SUB 80,01; SUB 00,01; ADD FF,FF -> r=7F/ovf1, FF/borrow1/ovf0, FE/carry1/ovf0,
//    one result per cycle, in order.
//  3 INC FF, DEC 00, AND FF,FF, XOR FF,AA, NOT 55, NOP -> 00 c1, FF b1, FF, 55, AA, 00 (flags 0).
//  4 out_ready=0 for 5 cycles with 3 ops offered -> in_ready drops after 2 accepted, r stable,
//    no loss/duplication after release; clr_sticky same cycle as ovf delivery -> sticky=0.
//  5 assert reset with 2 ops in flight -> next cycle out_valid=0, r=0, sticky=0; no stale output.
//  6 ALU_ACC_EN: ADD 05,03 then INC acc_sel=1 back-to-back -> 08 then 09; WIDTH=16: ADD 7FFF,0001
//    -> 8000 ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code definitions for the pipelined ALU, its sequencer and bench.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP = 3'b000;
    localparam op_t OP_ADD = 3'b001;
    localparam op_t OP_SUB = 3'b010;
    localparam op_t OP_INC = 3'b011;
    localparam op_t OP_DEC = 3'b100;
    localparam op_t OP_AND = 3'b101;
    localparam op_t OP_XOR = 3'b110;
    localparam op_t OP_NOT = 3'b111;

endpackage

// File: rtl/alu_core_nbits.sv
// Combinational WIDTH-bit ALU: result, carry/borrow and signed overflow per op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
import alu_pkg::*;

module alu_core_nbits #(
    parameter int WIDTH = 8
) (
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_r,
    output logic             o_carry,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_opnd;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    // INC/DEC reuse the adder/subtractor with a constant 1 as second operand.
    assign w_opnd = (i_op == OP_INC || i_op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : i_b;
    assign w_sum  = {1'b0, i_a} + {1'b0, w_opnd};
    // Top bit of the extended difference is the borrow (a < operand, unsigned).
    assign w_diff = {1'b0, i_a} - {1'b0, w_opnd};

    // Select result and flags; logic ops and NOP never raise carry or overflow.
    always_comb begin
        o_r     = '0;
        o_carry = 1'b0;
        o_ovf   = 1'b0;
        case (i_op)
            OP_ADD, OP_INC: begin
                o_r     = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
                o_ovf   = (i_a[WIDTH-1] == w_opnd[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                o_r     = w_diff[WIDTH-1:0];
                o_carry = w_diff[WIDTH];
                o_ovf   = (i_a[WIDTH-1] != w_opnd[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  o_r = i_a & i_b;
            OP_XOR:  o_r = i_a ^ i_b;
            OP_NOT:  o_r = ~i_a;
            default: o_r = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe_nbits.sv
// Two-stage valid/ready ALU pipeline with sticky overflow; ALU_ACC_EN adds an accumulator operand.
// Latency: 2 cycles from accept to out_valid; 1 op/cycle sustained.
// Backpressure: out_ready low freezes stage 2; stage 1 fills, then in_ready drops (no path from in_valid).
import alu_pkg::*;

module alu_pipe_nbits #(
    parameter int WIDTH  = 8,
    parameter int STICKY = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_acc_sel,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_r,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_ovf_sticky,
    input  logic             i_clr_sticky
);

    logic             r_s1_vld;
    op_t              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_r;
    logic             r_carry;
    logic             r_ovf;
    logic             r_sticky;

    logic             w_adv2;
    logic             w_accept;
    logic             w_move;
    logic             w_deliver;
    logic [WIDTH-1:0] w_core_a;
    logic [WIDTH-1:0] w_core_r;
    logic             w_core_carry;
    logic             w_core_ovf;

    assign w_adv2     = !r_out_vld || i_out_ready;
    assign o_in_ready = !r_s1_vld || w_adv2;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_move     = r_s1_vld && w_adv2;
    assign w_deliver  = r_out_vld && i_out_ready;

`ifdef ALU_ACC_EN
    logic             r_s1_acc_sel;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_fwd;

    // The predecessor is either still in stage 2 (pending) or already folded into acc.
    assign w_acc_fwd = r_out_vld ? r_r : r_acc;
    assign w_core_a  = r_s1_acc_sel ? w_acc_fwd : r_s1_a;

    // Accumulator follows every delivered result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_acc_sel <= 1'b0;
            r_acc        <= '0;
        end else begin
            if (w_accept)  r_s1_acc_sel <= i_acc_sel;
            if (w_deliver) r_acc        <= r_r;
        end
    end
`else
    logic w_unused_acc_sel;

    assign w_unused_acc_sel = i_acc_sel;
    assign w_core_a         = r_s1_a;
`endif

    alu_core_nbits #(.WIDTH(WIDTH)) u_core (
        .i_op    (r_s1_op),
        .i_a     (w_core_a),
        .i_b     (r_s1_b),
        .o_r     (w_core_r),
        .o_carry (w_core_carry),
        .o_ovf   (w_core_ovf)
    );

    // Stage 1: capture the offered operation; drain into stage 2 when it can advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_vld <= 1'b0;
            r_s1_op  <= OP_NOP;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
        end else if (w_accept) begin
            r_s1_vld <= 1'b1;
            r_s1_op  <= i_op;
            r_s1_a   <= i_a;
            r_s1_b   <= i_b;
        end else if (w_move) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Stage 2: register the evaluated result; hold it steady while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_vld <= 1'b0;
            r_r       <= '0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_move) begin
            r_out_vld <= 1'b1;
            r_r       <= w_core_r;
            r_carry   <= w_core_carry;
            r_ovf     <= w_core_ovf;
        end else if (w_deliver) begin
            r_out_vld <= 1'b0;
        end
    end

    // Sticky overflow counts delivered results only; a clear beats a same-cycle set.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr_sticky) begin
            r_sticky <= 1'b0;
        end else if (STICKY != 0 && w_deliver && r_ovf) begin
            r_sticky <= 1'b1;
        end
    end

    assign o_out_valid  = r_out_vld;
    assign o_r          = r_r;
    assign o_carry      = r_carry;
    assign o_ovf        = r_ovf;
    assign o_ovf_sticky = r_sticky;

endmodule
